// File: rtl/sprite_animator.sv
// Sprite walker: latches spawn/despawn requests and, once per video frame,
// steps a sprite toward its target while cycling its walk-animation frames.
module sprite_animator #(
  parameter int NUM_FRAMES = 5,
  parameter int FRAME_HOLD = 6,
  parameter int SPEED      = 2
) (
  input  logic        clk_pixel,
  input  logic        sys_rst,
  input  logic        new_frame,
  input  logic        spawn_in,
  input  logic [10:0] spawn_x_in,
  input  logic [9:0]  spawn_y_in,
  input  logic [10:0] target_x_in,
  input  logic [9:0]  target_y_in,
  input  logic        despawn_in,
  output logic        sprite_valid,
  output logic [10:0] sprite_x,
  output logic [9:0]  sprite_y,
  output logic [7:0]  sprite_frame_number,
  output logic        arrived_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, ARRIVED = 2'd2} state_t;
  typedef enum logic [1:0] {CMD_NONE = 2'd0, CMD_SPAWN = 2'd1, CMD_DESPAWN = 2'd2} cmd_t;

  localparam logic [10:0] STEP_X     = 11'(SPEED);
  localparam logic [9:0]  STEP_Y     = 10'(SPEED);
  localparam logic [7:0]  LAST_FRAME = 8'(NUM_FRAMES - 1);
  localparam logic [7:0]  LAST_HOLD  = 8'(FRAME_HOLD - 1);

  state_t      state_r, state_s;
  cmd_t        cmd_r, cmd_s, eff_cmd_s;
  logic [10:0] pend_sx_r, pend_sx_s, pend_tx_r, pend_tx_s, eff_sx_s, eff_tx_s;
  logic [9:0]  pend_sy_r, pend_sy_s, pend_ty_r, pend_ty_s, eff_sy_s, eff_ty_s;
  logic [10:0] tgt_x_r, tgt_x_s, x_r, x_s, move_x_s;
  logic [9:0]  tgt_y_r, tgt_y_s, y_r, y_s, move_y_s;
  logic [7:0]  frame_r, frame_s, hold_r, hold_s;
  logic        valid_r, valid_s, arrived_r, arrived_s;

  // Closest clamp: never overshoots, so no wrap is possible.
  function automatic logic [10:0] approach_x(input logic [10:0] pos, input logic [10:0] tgt);
    if (tgt > pos) begin
      approach_x = ((tgt - pos) < STEP_X) ? tgt : pos + STEP_X;
    end else begin
      approach_x = ((pos - tgt) < STEP_X) ? tgt : pos - STEP_X;
    end
  endfunction

  function automatic logic [9:0] approach_y(input logic [9:0] pos, input logic [9:0] tgt);
    if (tgt > pos) begin
      approach_y = ((tgt - pos) < STEP_Y) ? tgt : pos + STEP_Y;
    end else begin
      approach_y = ((pos - tgt) < STEP_Y) ? tgt : pos - STEP_Y;
    end
  endfunction

  // Next-state logic: merge this cycle's request over the pending one, commit at new_frame.
  always_comb begin
    state_s   = state_r;
    cmd_s     = cmd_r;
    pend_sx_s = pend_sx_r;
    pend_sy_s = pend_sy_r;
    pend_tx_s = pend_tx_r;
    pend_ty_s = pend_ty_r;
    tgt_x_s   = tgt_x_r;
    tgt_y_s   = tgt_y_r;
    x_s       = x_r;
    y_s       = y_r;
    frame_s   = frame_r;
    hold_s    = hold_r;
    valid_s   = valid_r;
    arrived_s = 1'b0;
    move_x_s  = approach_x(x_r, tgt_x_r);
    move_y_s  = approach_y(y_r, tgt_y_r);

    eff_cmd_s = cmd_r;
    eff_sx_s  = pend_sx_r;
    eff_sy_s  = pend_sy_r;
    eff_tx_s  = pend_tx_r;
    eff_ty_s  = pend_ty_r;
    if (despawn_in) begin
      eff_cmd_s = CMD_DESPAWN;
    end else if (spawn_in) begin
      eff_cmd_s = CMD_SPAWN;
      eff_sx_s  = spawn_x_in;
      eff_sy_s  = spawn_y_in;
      eff_tx_s  = target_x_in;
      eff_ty_s  = target_y_in;
    end else begin
      eff_cmd_s = cmd_r;
    end

    if (new_frame) begin
      cmd_s = CMD_NONE;
      case (eff_cmd_s)
        CMD_SPAWN: begin
          x_s     = eff_sx_s;
          y_s     = eff_sy_s;
          tgt_x_s = eff_tx_s;
          tgt_y_s = eff_ty_s;
          frame_s = 8'd0;
          hold_s  = 8'd0;
          valid_s = 1'b1;
          state_s = WALK;
        end
        CMD_DESPAWN: begin
          valid_s = 1'b0;
          state_s = IDLE;
        end
        default: begin
          if (state_r == WALK) begin
            x_s = move_x_s;
            y_s = move_y_s;
            if ((move_x_s == tgt_x_r) && (move_y_s == tgt_y_r)) begin
              state_s   = ARRIVED;
              frame_s   = 8'd0;
              hold_s    = 8'd0;
              arrived_s = 1'b1;
            end else if (hold_r == LAST_HOLD) begin
              hold_s  = 8'd0;
              frame_s = (frame_r == LAST_FRAME) ? 8'd0 : frame_r + 8'd1;
            end else begin
              hold_s = hold_r + 8'd1;
            end
          end else begin
            state_s = state_r;
          end
        end
      endcase
    end else begin
      cmd_s     = eff_cmd_s;
      pend_sx_s = eff_sx_s;
      pend_sy_s = eff_sy_s;
      pend_tx_s = eff_tx_s;
      pend_ty_s = eff_ty_s;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      state_r   <= IDLE;
      cmd_r     <= CMD_NONE;
      pend_sx_r <= 11'd0;
      pend_sy_r <= 10'd0;
      pend_tx_r <= 11'd0;
      pend_ty_r <= 10'd0;
      tgt_x_r   <= 11'd0;
      tgt_y_r   <= 10'd0;
      x_r       <= 11'd0;
      y_r       <= 10'd0;
      frame_r   <= 8'd0;
      hold_r    <= 8'd0;
      valid_r   <= 1'b0;
      arrived_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cmd_r     <= cmd_s;
      pend_sx_r <= pend_sx_s;
      pend_sy_r <= pend_sy_s;
      pend_tx_r <= pend_tx_s;
      pend_ty_r <= pend_ty_s;
      tgt_x_r   <= tgt_x_s;
      tgt_y_r   <= tgt_y_s;
      x_r       <= x_s;
      y_r       <= y_s;
      frame_r   <= frame_s;
      hold_r    <= hold_s;
      valid_r   <= valid_s;
      arrived_r <= arrived_s;
    end
  end

  assign sprite_valid        = valid_r;
  assign sprite_x            = x_r;
  assign sprite_y            = y_r;
  assign sprite_frame_number = frame_r;
  assign arrived_out         = arrived_r;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed scenarios then random traffic, all
// checked against a frame-level behavioural model of the sprite.
module tb_sprite_animator;
  localparam int NF = 5;
  localparam int FH = 6;
  localparam int SP = 2;

  logic        clk_pixel = 1'b0;
  logic        sys_rst = 1'b0, new_frame = 1'b0, spawn_in = 1'b0, despawn_in = 1'b0;
  logic [10:0] spawn_x_in = 11'd0, target_x_in = 11'd0;
  logic [9:0]  spawn_y_in = 10'd0, target_y_in = 10'd0;
  logic        sprite_valid, arrived_out;
  logic [10:0] sprite_x;
  logic [9:0]  sprite_y;
  logic [7:0]  sprite_frame_number;

  int total = 0;
  int bad = 0;

  // Model: pending request, sprite position/target, and walk-frame count.
  int pend = 0, p_sx = 0, p_sy = 0, p_tx = 0, p_ty = 0;
  int m_mode = 0, m_valid = 0, m_x = 0, m_y = 0, m_tx = 0, m_ty = 0;
  int m_walked = 0, m_frame = 0, m_arr = 0;

  always #5 clk_pixel = ~clk_pixel;

  sprite_animator #(.NUM_FRAMES(NF), .FRAME_HOLD(FH), .SPEED(SP)) dut (
    .clk_pixel(clk_pixel), .sys_rst(sys_rst), .new_frame(new_frame),
    .spawn_in(spawn_in), .spawn_x_in(spawn_x_in), .spawn_y_in(spawn_y_in),
    .target_x_in(target_x_in), .target_y_in(target_y_in), .despawn_in(despawn_in),
    .sprite_valid(sprite_valid), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_frame_number(sprite_frame_number), .arrived_out(arrived_out)
  );

  function automatic int toward(input int p, input int t);
    if (t > p) return p + (((t - p) < SP) ? (t - p) : SP);
    else return p - (((p - t) < SP) ? (p - t) : SP);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit nf, input bit sp, input bit dsp,
                      input int sx, input int sy, input int tx, input int ty);
    int c, csx, csy, ctx, cty;
    sys_rst = rst; new_frame = nf; spawn_in = sp; despawn_in = dsp;
    spawn_x_in = 11'(sx); spawn_y_in = 10'(sy);
    target_x_in = 11'(tx); target_y_in = 10'(ty);
    @(posedge clk_pixel); #1;
    sys_rst = 1'b0; new_frame = 1'b0; spawn_in = 1'b0; despawn_in = 1'b0;
    m_arr = 0;
    if (rst) begin
      pend = 0; m_mode = 0; m_valid = 0; m_x = 0; m_y = 0; m_walked = 0; m_frame = 0;
    end else begin
      c = pend; csx = p_sx; csy = p_sy; ctx = p_tx; cty = p_ty;
      if (dsp) c = 2;
      else if (sp) begin c = 1; csx = sx; csy = sy; ctx = tx; cty = ty; end
      if (nf) begin
        pend = 0;
        if (c == 1) begin
          m_mode = 1; m_valid = 1; m_x = csx; m_y = csy; m_tx = ctx; m_ty = cty;
          m_walked = 0; m_frame = 0;
        end else if (c == 2) begin
          m_mode = 0; m_valid = 0;
        end else if (m_mode == 1) begin
          m_walked++;
          m_x = toward(m_x, m_tx);
          m_y = toward(m_y, m_ty);
          if (m_x == m_tx && m_y == m_ty) begin
            m_mode = 2; m_frame = 0; m_arr = 1;
          end else begin
            m_frame = (m_walked / FH) % NF;
          end
        end
      end else begin
        pend = c; p_sx = csx; p_sy = csy; p_tx = ctx; p_ty = cty;
      end
    end
    chk("valid", sprite_valid, m_valid);
    chk("x", sprite_x, m_x);
    chk("y", sprite_y, m_y);
    chk("frame", sprite_frame_number, m_frame);
    chk("arrived", arrived_out, m_arr);
  endtask

  initial begin
    // Reset held two cycles, then new_frames must not disturb anything.
    step(1, 1, 1, 0, 5, 5, 9, 9);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", sprite_valid, 0);
    chk("rst_x", sprite_x, 0);
    chk("rst_frame", sprite_frame_number, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("idle_nf_valid", sprite_valid, 0);

    // Horizontal walk, spawn mid-frame.
    step(0, 0, 1, 0, 100, 200, 106, 200);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_frame_valid", sprite_valid, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("commit_x", sprite_x, 100);
    chk("commit_y", sprite_y, 200);
    chk("commit_valid", sprite_valid, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("walk_x1", sprite_x, 102);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("walk_x2", sprite_x, 104);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("walk_x3", sprite_x, 106);
    chk("arrive_pulse", arrived_out, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pulse_single", arrived_out, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("held_x", sprite_x, 106);

    // Diagonal walk; request in the same cycle as new_frame commits at once.
    step(0, 1, 1, 0, 100, 50, 105, 47);
    chk("diag_commit_x", sprite_x, 100);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("diag1_y", sprite_y, 48);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("diag2_x", sprite_x, 104);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("diag3_x", sprite_x, 105);
    chk("diag3_arrived", arrived_out, 1);

    // Long walk exercises animation hold and wrap.
    step(0, 1, 1, 0, 0, 0, 2000, 0);
    for (int k = 1; k <= 31; k++) begin
      step(0, 1, 0, 0, 0, 0, 0, 0);
      if (k == 5) chk("anim_hold5", sprite_frame_number, 0);
      if (k == 6) chk("anim_adv6", sprite_frame_number, 1);
      if (k == 30) chk("anim_wrap30", sprite_frame_number, 0);
    end

    // Spawn already on target.
    step(0, 1, 1, 0, 300, 300, 300, 300);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("zero_walk_arr", arrived_out, 1);
    chk("zero_walk_x", sprite_x, 300);

    // Last request wins; simultaneous spawn+despawn is a despawn.
    step(0, 0, 1, 0, 10, 10, 20, 10);
    step(0, 0, 1, 0, 40, 30, 80, 30);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("last_wins_x", sprite_x, 40);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 1, 2, 2);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("both_valid", sprite_valid, 0);
    chk("both_arr", arrived_out, 0);
    chk("both_x_held", sprite_x, 42);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 7, 8, 9, 8);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("spawn_after_despawn", sprite_x, 7);

    // Reset mid-walk with a spawn pending.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 500, 500, 600, 500);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_walk_valid", sprite_valid, 0);
    chk("rst_walk_x", sprite_x, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_walk_after", sprite_valid, 0);

    // Random traffic with targets near the spawn point so arrivals happen.
    for (int i = 0; i < 4000; i++) begin
      int sx, sy, tx, ty;
      bit r, n, s, d;
      sx = $urandom_range(0, 2047);
      sy = $urandom_range(0, 1023);
      tx = $urandom_range((sx > 20) ? sx - 20 : 0, (sx + 20 > 2047) ? 2047 : sx + 20);
      ty = $urandom_range((sy > 20) ? sy - 20 : 0, (sy + 20 > 1023) ? 1023 : sy + 20);
      r = ($urandom_range(0, 499) == 0);
      n = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 39) == 0);
      d = ($urandom_range(0, 119) == 0);
      step(r, n, s, d, sx, sy, tx, ty);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
